// File: rtl/if_window_writer.sv
// if_window_writer: drains the IF input buffer into a circular scratchpad,
// keeps an exact occupancy count and a queue of completed window end
// addresses. The oldest window is presented to the PE address generator and
// can be released fully or partially, so consecutive windows may overlap.
// The consumer's release strobe is called release_req because "release" is a
// reserved word in SystemVerilog.
module if_window_writer #(
    parameter int ADDR_LEN      = 4,
    parameter int SCRATCH_DEPTH = 16,
    parameter int SCRATCH_WIDTH = 16,
    parameter int WIN_QDEPTH    = 4,
    parameter int QCNT_LEN      = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     buf_empty,
    input  logic                     buf_end,
    input  logic [SCRATCH_WIDTH-1:0] buf_data,
    output logic                     buf_read,
    output logic                     scratch_wen,
    output logic [ADDR_LEN-1:0]      scratch_waddr,
    output logic [SCRATCH_WIDTH-1:0] scratch_wdata,
    input  logic                     release_req,
    input  logic [ADDR_LEN-1:0]      release_keep,
    output logic                     win_valid,
    output logic [ADDR_LEN-1:0]      win_start,
    output logic [ADDR_LEN-1:0]      win_end,
    output logic [QCNT_LEN-1:0]      win_count,
    output logic [ADDR_LEN:0]        occupancy,
    output logic                     full,
    output logic [1:0]               err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        FILL  = 2'd2
    } state_e;

    // Pointer arithmetic is done one bit wider than an address so that a
    // single conditional add/subtract of the depth performs the wrap.
    localparam int                  PW       = ADDR_LEN + 1;
    localparam logic [PW-1:0]       DEPTH    = PW'(SCRATCH_DEPTH);
    localparam logic [ADDR_LEN-1:0] LAST     = ADDR_LEN'(SCRATCH_DEPTH - 1);
    localparam logic [QCNT_LEN-1:0] QDEPTH   = QCNT_LEN'(WIN_QDEPTH);

    state_e                state_q, state_d;
    logic [ADDR_LEN-1:0]   wptr_q, wptr_d;
    logic [ADDR_LEN-1:0]   rptr_q, rptr_d;
    logic [PW-1:0]         occ_q, occ_d;
    logic [QCNT_LEN-1:0]   cnt_q, cnt_d;
    logic [1:0]            err_q, err_d;
    // End-address queue, head at index 0; popping shifts toward the head.
    logic [ADDR_LEN-1:0]   endq_q [WIN_QDEPTH];
    logic [ADDR_LEN-1:0]   endq_d [WIN_QDEPTH];

    logic                  in_fill;
    logic                  is_full;
    logic                  has_win;
    logic                  release_fire;
    logic                  push_ok;
    logic                  wr;
    logic                  push;
    logic [QCNT_LEN-1:0]   push_idx;
    logic [PW-1:0]         span;
    logic [PW-1:0]         win_len;
    logic [PW-1:0]         keep_ext;
    logic                  keep_ok;
    logic [PW-1:0]         keep_amt;
    logic [PW-1:0]         after_end;
    logic [PW-1:0]         new_rptr;
    logic [PW-1:0]         retire;

    // Write/release qualification and oldest-window arithmetic.
    always_comb begin
        // NOTE: every signal driven here gets a value on every path; that is
        // what keeps combinational blocks from inferring latches.
        in_fill      = (state_q == FILL);
        is_full      = (occ_q == DEPTH);
        has_win      = (cnt_q != '0);
        release_fire = release_req & has_win & in_fill;
        push_ok      = ~buf_end | (cnt_q < QDEPTH) | release_fire;
        // A start pulse discards the scratch contents, so nothing is popped
        // from the buffer while it is asserted.
        wr           = in_fill & ~start & ~buf_empty & ~is_full & ~err_q[1] & push_ok;
        push         = wr & buf_end;
        push_idx     = cnt_q - QCNT_LEN'(release_fire);

        // Window length L = ((end - start) mod depth) + 1.
        span = {1'b0, endq_q[0]} - {1'b0, rptr_q};
        if (span[PW-1]) begin
            span = span + DEPTH;
        end
        win_len = span + 1'b1;

        // Retaining K >= L words is meaningless; fall back to a full release.
        keep_ext = {1'b0, release_keep};
        keep_ok  = (keep_ext < win_len);
        keep_amt = keep_ok ? keep_ext : '0;

        // New read pointer = (end + 1 - K) mod depth.
        after_end = {1'b0, endq_q[0]} + 1'b1;
        if (after_end == DEPTH) begin
            after_end = '0;
        end
        if (after_end < keep_amt) begin
            new_rptr = after_end + DEPTH - keep_amt;
        end else begin
            new_rptr = after_end - keep_amt;
        end
        retire = win_len - keep_amt;
    end

    // Next-state computation for pointers, occupancy, queue, errors and FSM.
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        occ_d   = occ_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        endq_d  = endq_q;

        if (state_q == CLEAR) begin
            state_d = FILL;
        end

        if (wr) begin
            wptr_d = (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
        end

        occ_d = occ_q + PW'(wr) - (release_fire ? retire : '0);
        cnt_d = cnt_q + QCNT_LEN'(push) - QCNT_LEN'(release_fire);

        if (release_fire) begin
            rptr_d = new_rptr[ADDR_LEN-1:0];
            if (!keep_ok) begin
                err_d[0] = 1'b1;
            end
            for (int i = 0; i < WIN_QDEPTH - 1; i++) begin
                endq_d[i] = endq_q[i+1];
            end
            endq_d[WIN_QDEPTH-1] = '0;
        end

        // Pushed after the pop shift so push and pop in one cycle both land.
        if (push) begin
            for (int i = 0; i < WIN_QDEPTH; i++) begin
                if (QCNT_LEN'(i) == push_idx) begin
                    endq_d[i] = wptr_q;
                end
            end
        end

        // Scratch full with no completed window: the window cannot fit.
        if (in_fill && is_full && !has_win) begin
            err_d[1] = 1'b1;
        end

        if (start || state_q == CLEAR) begin
            state_d = start ? CLEAR : FILL;
            wptr_d  = '0;
            rptr_d  = '0;
            occ_d   = '0;
            cnt_d   = '0;
            err_d   = '0;
            for (int i = 0; i < WIN_QDEPTH; i++) begin
                endq_d[i] = '0;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples its pre-edge value regardless of statement order.
        if (!rst) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            occ_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            // NOTE: the end queue is a handful of flops and is reset
            // explicitly so win_end reads 0 straight out of reset.
            for (int i = 0; i < WIN_QDEPTH; i++) begin
                endq_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            occ_q   <= occ_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            endq_q  <= endq_d;
        end
    end

    assign buf_read      = wr;
    assign scratch_wen   = wr;
    assign scratch_waddr = wptr_q;
    assign scratch_wdata = buf_data;
    assign win_valid     = has_win;
    assign win_start     = rptr_q;
    assign win_end       = endq_q[0];
    assign win_count     = cnt_q;
    assign occupancy     = occ_q;
    assign full          = is_full;
    assign err           = err_q;

endmodule

// File: tb/tb_if_window_writer.sv
// Testbench for if_window_writer: scenario tasks drive the buffer/consumer
// side; every expected scratch write is queued when its word is presented and
// matched against the DUT write strobe in the same cycle.
module tb_if_window_writer;

    localparam int AL = 4;
    localparam int SD = 16;
    localparam int SW = 16;
    localparam int WQ = 4;
    localparam int QL = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          buf_empty;
    logic          buf_end;
    logic [SW-1:0] buf_data;
    logic          buf_read;
    logic          scratch_wen;
    logic [AL-1:0] scratch_waddr;
    logic [SW-1:0] scratch_wdata;
    logic          release_req;
    logic [AL-1:0] release_keep;
    logic          win_valid;
    logic [AL-1:0] win_start;
    logic [AL-1:0] win_end;
    logic [QL-1:0] win_count;
    logic [AL:0]   occupancy;
    logic          full;
    logic [1:0]    err;

    typedef struct packed {
        logic [AL-1:0] addr;
        logic [SW-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    logic [AL-1:0] exp_wptr;
    int            n_tests;
    int            n_fail;

    if_window_writer #(
        .ADDR_LEN(AL), .SCRATCH_DEPTH(SD), .SCRATCH_WIDTH(SW),
        .WIN_QDEPTH(WQ), .QCNT_LEN(QL)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .buf_empty(buf_empty), .buf_end(buf_end), .buf_data(buf_data),
        .buf_read(buf_read), .scratch_wen(scratch_wen),
        .scratch_waddr(scratch_waddr), .scratch_wdata(scratch_wdata),
        .release_req(release_req), .release_keep(release_keep),
        .win_valid(win_valid), .win_start(win_start), .win_end(win_end),
        .win_count(win_count), .occupancy(occupancy), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock: scoreboard the write strobe at negedge, then step past posedge.
    task automatic tick();
        wr_t e;
        @(negedge clk);
        if (scratch_wen) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_write: unexpected write addr=%0d data=%h, required no write",
                         scratch_waddr, scratch_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({scratch_waddr, scratch_wdata} !== {e.addr, e.data}) begin
                    n_fail++;
                    $display("FAIL sb_write: got addr=%0d data=%h, required addr=%0d data=%h",
                             scratch_waddr, scratch_wdata, e.addr, e.data);
                end
            end
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_missing: %0d expected write(s) not performed, next addr=%0d",
                     exp_q.size(), exp_q[0].addr);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        start        = 1'b0;
        buf_empty    = 1'b1;
        buf_end      = 1'b0;
        release_req  = 1'b0;
        release_keep = '0;
    endtask

    task automatic drive_word(input logic [SW-1:0] d, input logic e, input logic expect_wr);
        buf_empty = 1'b0;
        buf_data  = d;
        buf_end   = e;
        if (expect_wr) begin
            exp_q.push_back({exp_wptr, d});
            exp_wptr = (exp_wptr == AL'(SD - 1)) ? '0 : exp_wptr + 1'b1;
        end
    endtask

    // n words, buf_end on every end_every-th word (0 = never); all expected written.
    task automatic write_words(input int n, input int end_every);
        for (int i = 0; i < n; i++) begin
            drive_word(SW'($urandom), (end_every != 0) && ((i + 1) % end_every == 0), 1'b1);
            tick();
        end
        idle_in();
    endtask

    task automatic do_start();
        idle_in();
        start = 1'b1;
        tick();
        start    = 1'b0;
        exp_wptr = '0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_in();
        buf_data = 16'hA5A5;
        exp_wptr = '0;
        repeat (2) tick();
        n_tests++;
        if ({buf_read, scratch_wen, scratch_waddr, win_valid, win_start, win_end,
             win_count, occupancy, full, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rd=%b wen=%b wa=%0d v=%b ws=%0d we=%0d cnt=%0d occ=%0d full=%b err=%b, required all 0",
                     buf_read, scratch_wen, scratch_waddr, win_valid, win_start, win_end,
                     win_count, occupancy, full, err);
        end
        n_tests++;
        if (scratch_wdata !== 16'hA5A5) begin
            n_fail++;
            $display("FAIL reset_wdata: got %h, required a5a5", scratch_wdata);
        end
        rst = 1'b1;
    endtask

    task automatic test_single_window();
        do_start();
        write_words(4, 0);
        n_tests++;
        if ({win_valid, occupancy} !== {1'b0, 5'd4}) begin
            n_fail++;
            $display("FAIL single_pre_end: got valid=%b occ=%0d, required valid=0 occ=4", win_valid, occupancy);
        end
        drive_word(SW'($urandom), 1'b1, 1'b1);
        tick();
        idle_in();
        n_tests++;
        if ({win_valid, win_start, win_end, occupancy, win_count} !== {1'b1, 4'd0, 4'd4, 5'd5, 3'd1}) begin
            n_fail++;
            $display("FAIL single_window: got v=%b ws=%0d we=%0d occ=%0d cnt=%0d, required v=1 ws=0 we=4 occ=5 cnt=1",
                     win_valid, win_start, win_end, occupancy, win_count);
        end
        release_req = 1'b1;
        tick();
        idle_in();
        n_tests++;
        if ({win_valid, win_start, occupancy, win_count, err} !== {1'b0, 4'd5, 5'd0, 3'd0, 2'b00}) begin
            n_fail++;
            $display("FAIL single_release: got v=%b ws=%0d occ=%0d cnt=%0d err=%b, required v=0 ws=5 occ=0 cnt=0 err=00",
                     win_valid, win_start, occupancy, win_count, err);
        end
    endtask

    task automatic test_keep();
        write_words(8, 8);
        n_tests++;
        if ({win_start, win_end, occupancy, win_count} !== {4'd5, 4'd12, 5'd8, 3'd1}) begin
            n_fail++;
            $display("FAIL keep_window: got ws=%0d we=%0d occ=%0d cnt=%0d, required ws=5 we=12 occ=8 cnt=1",
                     win_start, win_end, occupancy, win_count);
        end
        release_req  = 1'b1;
        release_keep = 4'd2;
        tick();
        idle_in();
        n_tests++;
        if ({win_valid, win_start, occupancy, err} !== {1'b0, 4'd11, 5'd2, 2'b00}) begin
            n_fail++;
            $display("FAIL keep_release: got v=%b ws=%0d occ=%0d err=%b, required v=0 ws=11 occ=2 err=00",
                     win_valid, win_start, occupancy, err);
        end
        // Extended window 11..2 crosses the 15 -> 0 wrap.
        write_words(6, 6);
        n_tests++;
        if ({win_valid, win_start, win_end, occupancy} !== {1'b1, 4'd11, 4'd2, 5'd8}) begin
            n_fail++;
            $display("FAIL keep_wrap: got v=%b ws=%0d we=%0d occ=%0d, required v=1 ws=11 we=2 occ=8",
                     win_valid, win_start, win_end, occupancy);
        end
        release_req  = 1'b1;
        release_keep = 4'd9;
        tick();
        idle_in();
        n_tests++;
        if ({err, win_start, occupancy, win_count} !== {2'b01, 4'd3, 5'd0, 3'd0}) begin
            n_fail++;
            $display("FAIL keep_illegal: got err=%b ws=%0d occ=%0d cnt=%0d, required err=01 ws=3 occ=0 cnt=0",
                     err, win_start, occupancy, win_count);
        end
    endtask

    task automatic test_reset_mid_fill();
        write_words(3, 0);
        rst = 1'b0;
        idle_in();
        tick();
        rst      = 1'b1;
        exp_wptr = '0;
        n_tests++;
        if ({buf_read, scratch_wen, scratch_waddr, win_valid, win_start, win_end,
             win_count, occupancy, full, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_fill: got wa=%0d v=%b ws=%0d we=%0d cnt=%0d occ=%0d full=%b err=%b, required all 0",
                     scratch_waddr, win_valid, win_start, win_end, win_count, occupancy, full, err);
        end
        drive_word(SW'($urandom), 1'b0, 1'b0);
        #1;
        n_tests++;
        if (buf_read !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_read: got buf_read=%b, required 0", buf_read);
        end
        tick();
        idle_in();
    endtask

    task automatic test_full_queue();
        do_start();
        write_words(16, 4);
        n_tests++;
        if ({win_count, full, occupancy, scratch_waddr, err} !== {3'd4, 1'b1, 5'd16, 4'd0, 2'b00}) begin
            n_fail++;
            $display("FAIL full_queue: got cnt=%0d full=%b occ=%0d wa=%0d err=%b, required cnt=4 full=1 occ=16 wa=0 err=00",
                     win_count, full, occupancy, scratch_waddr, err);
        end
        drive_word(SW'($urandom), 1'b0, 1'b0);
        #1;
        n_tests++;
        if (buf_read !== 1'b0) begin
            n_fail++;
            $display("FAIL full_no_read: got buf_read=%b, required 0", buf_read);
        end
        tick();
        idle_in();
    endtask

    task automatic test_back_to_back();
        logic [AL-1:0] exp_ws  [4] = '{4'd8, 4'd12, 4'd15, 4'd0};
        logic [AL-1:0] exp_we  [4] = '{4'd11, 4'd14, 4'd15, 4'd0};
        logic [AL:0]   exp_occ [4] = '{5'd8, 5'd4, 5'd1, 5'd0};
        logic [QL-1:0] exp_cnt [4] = '{3'd3, 3'd2, 3'd1, 3'd0};
        logic [SW-1:0] d;
        do_start();
        write_words(12, 4);
        write_words(3, 3);
        n_tests++;
        if ({win_count, occupancy, full, win_start, win_end} !== {3'd4, 5'd15, 1'b0, 4'd0, 4'd3}) begin
            n_fail++;
            $display("FAIL qfull_setup: got cnt=%0d occ=%0d full=%b ws=%0d we=%0d, required cnt=4 occ=15 full=0 ws=0 we=3",
                     win_count, occupancy, full, win_start, win_end);
        end
        d = SW'($urandom);
        drive_word(d, 1'b1, 1'b0);
        #1;
        n_tests++;
        if (buf_read !== 1'b0) begin
            n_fail++;
            $display("FAIL qfull_blocked: got buf_read=%b, required 0", buf_read);
        end
        tick();
        drive_word(d, 1'b1, 1'b1);
        release_req = 1'b1;
        #1;
        n_tests++;
        if (buf_read !== 1'b1) begin
            n_fail++;
            $display("FAIL qfull_push_pop_read: got buf_read=%b, required 1", buf_read);
        end
        tick();
        idle_in();
        n_tests++;
        if ({win_count, occupancy, win_start, win_end} !== {3'd4, 5'd12, 4'd4, 4'd7}) begin
            n_fail++;
            $display("FAIL qfull_push_pop: got cnt=%0d occ=%0d ws=%0d we=%0d, required cnt=4 occ=12 ws=4 we=7",
                     win_count, occupancy, win_start, win_end);
        end
        for (int k = 0; k < 4; k++) begin
            release_req = 1'b1;
            tick();
            idle_in();
            n_tests++;
            if ({win_start, occupancy, win_count} !== {exp_ws[k], exp_occ[k], exp_cnt[k]} ||
                (k < 3 && win_end !== exp_we[k])) begin
                n_fail++;
                $display("FAIL drain_%0d: got ws=%0d we=%0d occ=%0d cnt=%0d, required ws=%0d we=%0d occ=%0d cnt=%0d",
                         k, win_start, win_end, occupancy, win_count, exp_ws[k], exp_we[k], exp_occ[k], exp_cnt[k]);
            end
        end
    endtask

    task automatic test_err_oversize();
        do_start();
        write_words(16, 0);
        tick();
        n_tests++;
        if ({err, full, win_count} !== {2'b10, 1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL oversize_err: got err=%b full=%b cnt=%0d, required err=10 full=1 cnt=0",
                     err, full, win_count);
        end
        drive_word(SW'($urandom), 1'b1, 1'b0);
        release_req = 1'b1;
        #1;
        n_tests++;
        if (buf_read !== 1'b0) begin
            n_fail++;
            $display("FAIL oversize_blocked: got buf_read=%b, required 0", buf_read);
        end
        tick();
        do_start();
        n_tests++;
        if ({err, occupancy, full} !== {2'b00, 5'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL start_clears_err: got err=%b occ=%0d full=%b, required err=00 occ=0 full=0",
                     err, occupancy, full);
        end
    endtask

    task automatic test_start_mid_fill();
        logic [SW-1:0] d;
        write_words(3, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        d     = SW'($urandom);
        drive_word(d, 1'b1, 1'b0);
        #1;
        n_tests++;
        if (buf_read !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_no_read: got buf_read=%b, required 0", buf_read);
        end
        tick();
        exp_wptr = '0;
        drive_word(d, 1'b1, 1'b1);
        #1;
        n_tests++;
        if ({buf_read, scratch_waddr} !== {1'b1, 4'd0}) begin
            n_fail++;
            $display("FAIL restart_write: got buf_read=%b wa=%0d, required buf_read=1 wa=0", buf_read, scratch_waddr);
        end
        tick();
        idle_in();
        n_tests++;
        if ({occupancy, win_count, win_start, win_end} !== {5'd1, 3'd1, 4'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL restart_window: got occ=%0d cnt=%0d ws=%0d we=%0d, required occ=1 cnt=1 ws=0 we=0",
                     occupancy, win_count, win_start, win_end);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_single_window();
        test_keep();
        test_reset_mid_fill();
        test_full_queue();
        test_back_to_back();
        test_err_oversize();
        test_start_mid_fill();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
